// File: rtl/gray_to_rgb565_ise.sv
// gray_to_rgb565_ise
//   Custom-instruction slave that expands four packed 8-bit gray pixels into a
//   4x16-bit RGB565 buffer. LOAD converts one pixel per cycle. READ_LO and
//   READ_HI return two buffered pixels each. CLEAR zeroes the buffer.
//
// Ports
//   clock   : system clock, rising edge
//   reset   : synchronous reset, active low
//   start   : one-cycle instruction issue pulse
//   iseId   : instruction id, acted on only when equal to customInstructionId
//   valueA  : LOAD operand {g3,g2,g1,g0}
//   valueB  : [1:0] op (0 LOAD, 1 READ_LO, 2 READ_HI, 3 CLEAR)
//   done    : one-cycle completion pulse (registered)
//   result  : instruction result, zero whenever done is low (registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a selected start
// CONV  | LOAD in progress, one pixel expanded per cycle
// RESP  | drive done/result for one cycle, then return to IDLE

module gray_to_rgb565_ise #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_READ_LO = 2'd1;
    localparam logic [1:0] OP_READ_HI = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] gray_q;
    logic [15:0] pix [4];
    logic [1:0]  count;
    logic        valid;
    logic        sel;

    // R5 G6 B5 by truncation of the gray value
    function automatic logic [15:0] expand(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

    assign sel = start && (iseId == customInstructionId);

    // valid has no reader on this interface and the upper op bits are reserved
    logic unused_ok;
    assign unused_ok = &{1'b0, valueB[31:2], valid};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_LOAD;
            gray_q <= 32'd0;
            count  <= 2'd0;
            valid  <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                pix[i] <= 16'd0;
            end
        end else begin
            // done and result are single-cycle unless RESP drives them
            done   <= 1'b0;
            result <= 32'd0;

            case (state)
                IDLE: begin
                    if (sel) begin
                        op_q <= valueB[1:0];
                        if (valueB[1:0] == OP_LOAD) begin
                            gray_q <= valueA;
                            count  <= 2'd0;
                            valid  <= 1'b0;
                            state  <= CONV;
                        end else begin
                            state  <= RESP;
                        end
                    end
                end

                CONV: begin
                    pix[count] <= expand(gray_q[{count, 3'b000} +: 8]);
                    count      <= count + 2'd1;
                    if (count == 2'd3) begin
                        valid <= 1'b1;
                        state <= RESP;
                    end
                end

                RESP: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    case (op_q)
                        OP_READ_LO: result <= {pix[1], pix[0]};
                        OP_READ_HI: result <= {pix[3], pix[2]};
                        OP_CLEAR: begin
                            result <= 32'd0;
                            valid  <= 1'b0;
                            for (int i = 0; i < 4; i++) begin
                                pix[i] <= 16'd0;
                            end
                        end
                        default:    result <= 32'd0;
                    endcase
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_to_rgb565_ise.sv
module tb_gray_to_rgb565_ise;

    localparam logic [7:0] ID = 8'd0;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_READ_LO = 2'd1;
    localparam logic [1:0] OP_READ_HI = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    gray_to_rgb565_ise #(.customInstructionId(ID)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Issues one instruction and waits for done.
    task automatic run_op(input string tag, input logic [7:0] id, input logic [1:0] op,
                          input logic [31:0] a, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        start  = 1'b1;
        iseId  = id;
        valueA = a;
        valueB = {30'd0, op};
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        @(negedge clock);
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
        check({tag, " result idle"}, result, 32'd0);
    endtask

    initial begin
        int n_done;
        int first_done;

        reset  = 1'b0;
        start  = 1'b0;
        iseId  = ID;
        valueA = 32'd0;
        valueB = 32'd0;

        // 1: reset and idle
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        run_op("rd_lo after reset", ID, OP_READ_LO, 32'd0, 1, 32'h0000_0000);

        // 2: LOAD then reads
        run_op("load1", ID, OP_LOAD, 32'hFF80_4000, 5, 32'd0);
        run_op("load1 rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h4208_0000);
        run_op("load1 rd_hi", ID, OP_READ_HI, 32'd0, 1, 32'hFFFF_8410);
        run_op("load1 rd_lo again", ID, OP_READ_LO, 32'hFFFF_FFFF, 1, 32'h4208_0000);

        // 3: start with a foreign id
        start  = 1'b1;
        iseId  = ID + 8'd1;
        valueA = 32'h1234_5678;
        valueB = {30'd0, OP_LOAD};
        n_done = 0;
        @(negedge clock);
        start = 1'b0;
        iseId = ID;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("foreign id done count", n_done, 0);
        run_op("foreign id rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h4208_0000);

        // 4: reset in the middle of CONV
        start  = 1'b1;
        valueA = 32'hFFFF_FFFF;
        valueB = {30'd0, OP_LOAD};
        n_done = 0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (done) n_done++;
        end
        reset = 1'b0;
        @(negedge clock);
        if (done) n_done++;
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("abort done count", n_done, 0);
        run_op("abort rd_hi", ID, OP_READ_HI, 32'd0, 1, 32'h0000_0000);
        run_op("abort rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h0000_0000);

        // 5: LOAD, CLEAR, READ
        run_op("load2", ID, OP_LOAD, 32'h0102_0304, 5, 32'd0);
        run_op("load2 rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h0000_0020);
        run_op("clear", ID, OP_CLEAR, 32'd0, 1, 32'd0);
        run_op("clear rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h0000_0000);
        run_op("clear rd_hi", ID, OP_READ_HI, 32'd0, 1, 32'h0000_0000);

        // 6: extra start pulses while a LOAD is running
        start  = 1'b1;
        valueA = 32'h8040_FF00;
        valueB = {30'd0, OP_LOAD};
        @(negedge clock);
        valueA = 32'hFFFF_FFFF;
        n_done = 0;
        first_done = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 2) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
        end
        start = 1'b0;
        check("repulse done count", n_done, 1);
        check("repulse latency", first_done, 5);
        run_op("repulse rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'hFFFF_0000);
        run_op("repulse rd_hi", ID, OP_READ_HI, 32'd0, 1, 32'h8410_4208);

        // partial overwrite is not visible once CONV completes: new LOAD replaces all
        run_op("load3", ID, OP_LOAD, 32'h00FF_0080, 5, 32'd0);
        run_op("load3 rd_lo", ID, OP_READ_LO, 32'd0, 1, 32'h0000_8410);
        run_op("load3 rd_hi", ID, OP_READ_HI, 32'd0, 1, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
